// File: rtl/cfg_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_write_scheduler
//  Description : Sequences writes onto the neuron-network configuration bus.
//                After reset (or on init_start) every configuration register
//                receives INIT_VALUE, one register per cycle. SPI writes that
//                arrive in the meantime are queued and issued once the sweep
//                has finished, so host values always override the defaults.
//
//  Ports
//    clk         system clock, rising edge
//    reset       asynchronous reset, active low
//    spi_addr    SPI write address
//    spi_data    SPI write data
//    spi_we      single-cycle SPI write pulse
//    init_start  pulse: rerun the default sweep (ignored during a sweep)
//    ovf_clr     clears the sticky overflow flag
//    cfg_addr    configuration address (registered)
//    cfg_data    configuration data (registered)
//    cfg_we      configuration write strobe (registered)
//    busy        sweep in progress or SPI writes still queued
//    init_done   a sweep has completed and no new sweep is running
//    fifo_level  number of queued SPI writes
//    overflow    sticky: an SPI write was dropped because the queue was full
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_write_scheduler #(
    parameter int          ADDR_W     = 4,
    parameter int          DATA_W     = 8,
    parameter int          NUM_REGS   = 16,
    parameter int unsigned INIT_VALUE = 'h10,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 spi_addr,
    input  logic [DATA_W-1:0]                 spi_data,
    input  logic                              spi_we,
    input  logic                              init_start,
    input  logic                              ovf_clr,
    output logic [ADDR_W-1:0]                 cfg_addr,
    output logic [DATA_W-1:0]                 cfg_data,
    output logic                              cfg_we,
    output logic                              busy,
    output logic                              init_done,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow
);

    localparam int                c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                c_LVL_W = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] c_INIT  = DATA_W'(INIT_VALUE);
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;

    logic [ADDR_W-1:0]   r_mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;

    logic                r_cfg_we;
    logic [ADDR_W-1:0]   r_cfg_addr;
    logic [DATA_W-1:0]   r_cfg_data;
    logic                r_init_done;
    logic                r_overflow;

    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_done_nxt;
    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_drop;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_cfg_addr;
        w_data_nxt  = r_cfg_data;
        w_done_nxt  = r_init_done;
        case (r_state)
            ST_INIT: begin
                w_we_nxt   = 1'b1;
                w_addr_nxt = r_idx;
                w_data_nxt = c_INIT;
                w_done_nxt = 1'b0;
                if (r_idx == c_LAST) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt = r_idx + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (init_start) begin
                    // Queue is frozen until the new sweep completes
                    w_state_nxt = ST_INIT;
                    w_idx_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end else begin
                    w_done_nxt = 1'b1;
                    if (r_level != '0) begin
                        w_pop      = 1'b1;
                        w_we_nxt   = 1'b1;
                        w_addr_nxt = r_mem_addr[r_rd_ptr];
                        w_data_nxt = r_mem_data[r_rd_ptr];
                    end
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full queue still accepts
    assign w_full = (r_level == c_FULL);
    assign w_push = spi_we & (~w_full | w_pop);
    assign w_drop = spi_we & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_idx       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_cfg_we    <= 1'b0;
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_init_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cfg_we    <= w_we_nxt;
            r_cfg_addr  <= w_addr_nxt;
            r_cfg_data  <= w_data_nxt;
            r_init_done <= w_done_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear leaves the flag set
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    // Queue storage needs no reset: the level counter defines validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= spi_addr;
            r_mem_data[r_wr_ptr] <= spi_data;
        end
    end

    assign cfg_we     = r_cfg_we;
    assign cfg_addr   = r_cfg_addr;
    assign cfg_data   = r_cfg_data;
    assign init_done  = r_init_done;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;
    assign busy       = (r_state == ST_INIT) | (r_level != '0);

endmodule
`default_nettype wire
